conv_window_5x5: RTL and testbench
==================================

// Module: conv_window_5x5
// PURPOSE
//  Streaming 5x5 sliding-window generator that feeds the 25-operand CSA adder tree of the conv datapath.
//  Accepts one raster-order pixel per valid cycle and stores the previous 4 image rows in internal line buffers.
//  Emits a registered 25-tap window, one per accepted pixel, once a full 5x5 neighbourhood exists (valid-padding conv).
// PARAMETERS
//  BIT    16  pixel / operand width (same width as the adder tree operands)
//  IMG_W  28  image width in pixels, must be >= 5
//  IMG_H  28  image height in pixels, must be >= 5
// PORTS
//  clk         in   1          single clock, rising edge
//  rst_n       in   1          asynchronous, active-low reset
//  in_valid    in   1          in_pixel is valid this cycle; no backpressure, every valid pixel is consumed
//  in_pixel    in   BIT        pixel data, raster order (row-major, col 0 first)
//  out_valid   out  1          win holds a complete 5x5 window
//  win         out  25*BIT     tap k=5*r+c at win[BIT*k +: BIT]; r=0 oldest row, c=0 leftmost column
//  frame_done  out  1          1-cycle pulse after the last pixel of a frame is accepted
// BEHAVIOUR
//  Reset (async on rst_n=0): col=0, row=0, state=FILL, all 25 window regs=0, out_valid=0, frame_done=0.
//   Line-buffer RAM contents are not reset. Validity is gated by row/col only, so stale data never escapes.
//  Counters: col 0..IMG_W-1 and row 0..IMG_H-1. Both advance only on in_valid=1.
//   col wraps to 0 and row increments. At (IMG_H-1, IMG_W-1), both wrap to 0.
//  Line buffers: 4 rows x IMG_W, addressed by col. On each valid pixel, read col across rows 0..3 and shift each
//   row up by one (lb0<=lb1, lb1<=lb2, lb2<=lb3, lb3<=in_pixel) at that column.
//  Window: on each valid pixel, all 5 window rows shift left by one column. The new right column (c=4) is
//   {lb0,lb1,lb2,lb3,in_pixel}[col]. Tap 24 is therefore the just-accepted pixel.
//  FSM, 2 states:
//   FILL:   row<4. out_valid stays 0. Moves to ACTIVE when a valid pixel is accepted at col=IMG_W-1 with row=3.
//   ACTIVE: row>=4. Moves to FILL on frame wrap, i.e. a valid pixel accepted at (IMG_H-1, IMG_W-1).
//  out_valid (registered): next cycle =1 iff in_valid=1 this cycle and row>=4 and col>=4; otherwise 0.
//   Latency is 1 clk from accepting the pixel to window valid. win holds its value when no pixel is accepted.
//  Per frame: exactly (IMG_W-4)*(IMG_H-4) out_valid pulses. Windows never straddle a row edge (col<4 is suppressed).
//  frame_done (registered): =1 the cycle after the (IMG_H-1, IMG_W-1) pixel is accepted.
//   It coincides with that pixel's out_valid.
//  in_valid=0 bubbles: counters, line buffers, window and FSM all hold; out_valid and frame_done =0.
//  Back-to-back frames: the first pixel of the next frame may arrive the cycle after the last pixel of the
//   previous frame. There is no dead cycle. The new frame restarts in FILL, and old line data is ignored.
//  Reset mid-frame: everything returns to the reset state immediately. The next valid pixel is row 0, col 0.
//  Arithmetic: no pixel arithmetic happens in this block. Data passes through bit-exact, without sign handling.
//   Counter widths are $clog2 of IMG_W / IMG_H.
// TESTING  (bench uses IMG_W=8, IMG_H=8, BIT=16; pixel value = {row,col} as 16*row+col)
//  1 Stream one frame with in_valid=1 continuously. Expect the first out_valid 1 clk after pixel (4,4).
//    That window must have tap0=0x00, tap12=0x22, tap24=0x44. Expect exactly 16 valid windows in total.
//  2 Check each window against a reference model. Window at (r,c): tap 5*i+j = 16*(r-4+i)+(c-4+j).
//    Confirm no valid window is produced for col<4 or row<4.
//  3 Same frame with random in_valid bubbles (~40% low). Expect an identical sequence of 16 windows.
//    Expect out_valid never asserted the cycle after an in_valid=0 cycle.
//  4 Two back-to-back frames, where frame 2 pixel = 0x80+16*row+col. Expect frame_done=1 exactly once per frame,
//    16+16 windows, and frame-2 first window tap0=0x80, tap24=0xC4 with no frame-1 data.
//  5 Drive rst_n=0 for 1 cycle after pixel (5,2) of a frame, then restart a fresh frame.
//    Expect out_valid=0 and win=0 during reset, and correct windows from the restarted frame only.
//  6 Drive all pixels to 1 and connect win to the 25-input CSA adder tree. Every valid window must sum to 25.

Source files
------------

// File: rtl/conv_window_5x5_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_5x5_if
//  Purpose  : Pixel-in / window-out bundle between a pixel source and the
//             5x5 sliding-window generator.
//  Revision : 1.0  initial release
// ============================================================================
interface conv_window_5x5_if #(
    parameter int BIT = 16
);
    logic               in_valid;
    logic [BIT-1:0]     in_pixel;
    logic               out_valid;
    logic [25*BIT-1:0]  win;
    logic               frame_done;

    // Pixel source side
    modport master (
        output in_valid,
        output in_pixel,
        input  out_valid,
        input  win,
        input  frame_done
    );

    // Window generator side
    modport slave (
        input  in_valid,
        input  in_pixel,
        output out_valid,
        output win,
        output frame_done
    );
endinterface
`default_nettype wire

// File: rtl/conv_window_5x5.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_5x5
//  Purpose  : Streaming 5x5 sliding-window generator. Keeps the previous four
//             image rows in line buffers and emits one registered 25-tap
//             window per accepted pixel once a full neighbourhood exists.
//  Revision : 1.0  initial release
// ============================================================================
module conv_window_5x5 #(
    parameter int BIT   = 16,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    conv_window_5x5_if.slave bus
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(4);
    localparam logic [ROW_W-1:0] ROW_FILL  = ROW_W'(3);

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_done_q, frame_done_d;
    logic [BIT-1:0]   win_q [25];
    logic [BIT-1:0]   win_d [25];

    // Line buffer storage: plain RAM, never reset (stale rows are masked by the FSM)
    logic [BIT-1:0]   lb_mem [4][IMG_W];
    logic [BIT-1:0]   col_data [5];
    logic             last_col;
    logic             last_row;

    // Column of the neighbourhood that enters the window on this pixel
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            col_data[r] = lb_mem[r][col_q];
        end
        col_data[4] = bus.in_pixel;
    end

    // Next-state: raster counters, fill/active FSM, window shift and output flags
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        state_d      = state_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        win_d        = win_q;
        last_col     = (col_q == COL_LAST);
        last_row     = (row_q == ROW_LAST);
        if (bus.in_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            // Windows touching the left image edge would straddle two rows
            out_valid_d  = (state_q == ACTIVE) && (col_q >= COL_FIRST);
            frame_done_d = last_col && last_row;
            case (state_q)
                FILL:    if (last_col && row_q == ROW_FILL) state_d = ACTIVE;
                ACTIVE:  if (last_col && last_row)          state_d = FILL;
                default:                                    state_d = FILL;
            endcase
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win_d[5*r+c] = win_q[5*r+c+1];
                end
                win_d[5*r+4] = col_data[r];
            end
        end
    end

    // State, counter and window registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FILL;
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < 25; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    // Line buffers: each accepted pixel pushes its column one row older
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            lb_mem[0][col_q] <= lb_mem[1][col_q];
            lb_mem[1][col_q] <= lb_mem[2][col_q];
            lb_mem[2][col_q] <= lb_mem[3][col_q];
            lb_mem[3][col_q] <= bus.in_pixel;
        end
    end

    generate
        for (genvar k = 0; k < 25; k++) begin : g_tap
            assign bus.win[BIT*k +: BIT] = win_q[k];
        end
    endgenerate

    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;
endmodule
`default_nettype wire

// File: tb/tb_conv_window_5x5.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_window_5x5
//  Purpose  : Self-checking bench for conv_window_5x5 (8x8 image, 16-bit).
//             A frame image array plus a raster position is the reference:
//             every accepted pixel is stored, and each expected window is
//             read out of that image as the 5x5 block ending at the pixel.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_window_5x5;
    localparam int BIT = 16;
    localparam int W   = 8;
    localparam int H   = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    conv_window_5x5_if #(.BIT(BIT)) bus ();

    conv_window_5x5 #(.BIT(BIT), .IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [BIT-1:0] img [H][W];
    int m_row = 0;
    int m_col = 0;

    // mode 0: pixel = base + 16*row + col (base steps by 0x80 per frame)
    // mode 1: random pixels, mode 2: all ones (window sum must be 25)
    task automatic stream(input int npix, input int bubble_pct, input int mode,
                          output int nwin, output int ndone,
                          output logic [25*BIT-1:0] first_win);
        int sent = 0;
        int guard = 0;
        int base = 0;
        int s;
        bit v, exp_ov, exp_fd, grab, have_last;
        logic [BIT-1:0] pix;
        logic [25*BIT-1:0] exp_w, last_w;
        nwin = 0; ndone = 0; first_win = '0;
        grab = 1'b1; have_last = 1'b0; exp_w = '0; last_w = '0;
        while (sent < npix && guard < 20000) begin
            guard++;
            v = ($urandom_range(99) >= bubble_pct);
            case (mode)
                0:       pix = BIT'(base + 16*m_row + m_col);
                1:       pix = BIT'($urandom);
                default: pix = BIT'(1);
            endcase
            bus.in_valid = v;
            bus.in_pixel = pix;
            exp_ov = 1'b0;
            exp_fd = 1'b0;
            if (v) begin
                img[m_row][m_col] = pix;
                exp_ov = (m_row >= 4) && (m_col >= 4);
                exp_fd = (m_row == H-1) && (m_col == W-1);
                if (exp_ov)
                    for (int i = 0; i < 5; i++)
                        for (int j = 0; j < 5; j++)
                            exp_w[BIT*(5*i+j) +: BIT] = img[m_row-4+i][m_col-4+j];
            end
            @(posedge clk); #1;
            total++;
            if (bus.out_valid !== exp_ov) begin
                bad++;
                $display("FAIL out_valid at (%0d,%0d) v=%0b: got %b want %b", m_row, m_col, v, bus.out_valid, exp_ov);
            end
            total++;
            if (bus.frame_done !== exp_fd) begin
                bad++;
                $display("FAIL frame_done at (%0d,%0d): got %b want %b", m_row, m_col, bus.frame_done, exp_fd);
            end
            if (exp_ov) begin
                total++;
                if (bus.win !== exp_w) begin
                    bad++;
                    $display("FAIL window at (%0d,%0d): got %h want %h", m_row, m_col, bus.win, exp_w);
                end
                if (mode == 2) begin
                    s = 0;
                    for (int k = 0; k < 25; k++) s += int'(bus.win[BIT*k +: BIT]);
                    total++;
                    if (s != 25) begin
                        bad++;
                        $display("FAIL adder_tree_sum at (%0d,%0d): got %0d want 25", m_row, m_col, s);
                    end
                end
                if (grab) begin
                    first_win = bus.win;
                    grab = 1'b0;
                end
                nwin++;
                last_w = exp_w;
                have_last = 1'b1;
            end else if (!v && have_last) begin
                total++;
                if (bus.win !== last_w) begin
                    bad++;
                    $display("FAIL win_hold in bubble: got %h want %h", bus.win, last_w);
                end
            end else if (v) begin
                have_last = 1'b0;
            end
            if (bus.frame_done === 1'b1) ndone++;
            if (v) begin
                sent++;
                if (exp_fd) begin
                    grab = 1'b1;
                    base += 'h80;
                end
                if (m_col == W-1) begin
                    m_col = 0;
                    m_row = (m_row == H-1) ? 0 : m_row + 1;
                end else begin
                    m_col++;
                end
            end
        end
        bus.in_valid = 1'b0;
        if (sent < npix) begin
            total++;
            bad++;
            $display("FAIL stream_timeout: sent %0d want %0d", sent, npix);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++;
        if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); end
        total++;
        if (bus.win !== '0) begin bad++; $display("FAIL reset_win: got %h want 0", bus.win); end
        rst_n = 1'b1;
        m_row = 0;
        m_col = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_continuous();
        int nwin, ndone;
        logic [25*BIT-1:0] fw;
        stream(W*H, 0, 0, nwin, ndone, fw);
        total++;
        if (nwin != 16) begin bad++; $display("FAIL cont_window_count: got %0d want 16", nwin); end
        total++;
        if (ndone != 1) begin bad++; $display("FAIL cont_frame_done_count: got %0d want 1", ndone); end
        total++;
        if (fw[BIT*0 +: BIT] !== 16'h0000) begin bad++; $display("FAIL cont_tap0: got %h want 0000", fw[BIT*0 +: BIT]); end
        total++;
        if (fw[BIT*12 +: BIT] !== 16'h0022) begin bad++; $display("FAIL cont_tap12: got %h want 0022", fw[BIT*12 +: BIT]); end
        total++;
        if (fw[BIT*24 +: BIT] !== 16'h0044) begin bad++; $display("FAIL cont_tap24: got %h want 0044", fw[BIT*24 +: BIT]); end
    endtask

    task automatic test_bubbles();
        int nwin, ndone;
        logic [25*BIT-1:0] fw;
        stream(W*H, 40, 0, nwin, ndone, fw);
        total++;
        if (nwin != 16) begin bad++; $display("FAIL bubble_window_count: got %0d want 16", nwin); end
        total++;
        if (ndone != 1) begin bad++; $display("FAIL bubble_frame_done_count: got %0d want 1", ndone); end
    endtask

    task automatic test_back_to_back();
        int nwin, ndone;
        logic [25*BIT-1:0] fw;
        stream(2*W*H, 0, 0, nwin, ndone, fw);
        total++;
        if (nwin != 32) begin bad++; $display("FAIL b2b_window_count: got %0d want 32", nwin); end
        total++;
        if (ndone != 2) begin bad++; $display("FAIL b2b_frame_done_count: got %0d want 2", ndone); end
        total++;
        if (fw[BIT*0 +: BIT] !== 16'h0080) begin bad++; $display("FAIL b2b_f2_tap0: got %h want 0080", fw[BIT*0 +: BIT]); end
        total++;
        if (fw[BIT*24 +: BIT] !== 16'h00C4) begin bad++; $display("FAIL b2b_f2_tap24: got %h want 00c4", fw[BIT*24 +: BIT]); end
    endtask

    task automatic test_reset_mid_frame();
        int nwin, ndone;
        logic [25*BIT-1:0] fw;
        stream(5*W + 3, 0, 1, nwin, ndone, fw);
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        total++;
        if (bus.win !== '0) begin bad++; $display("FAIL midrst_win: got %h want 0", bus.win); end
        @(posedge clk); #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.win !== '0) begin
            bad++;
            $display("FAIL midrst_held: got ov=%b win=%h want ov=0 win=0", bus.out_valid, bus.win);
        end
        rst_n = 1'b1;
        m_row = 0;
        m_col = 0;
        stream(W*H, 30, 1, nwin, ndone, fw);
        total++;
        if (nwin != 16) begin bad++; $display("FAIL midrst_window_count: got %0d want 16", nwin); end
        total++;
        if (ndone != 1) begin bad++; $display("FAIL midrst_frame_done_count: got %0d want 1", ndone); end
    endtask

    task automatic test_adder_tree();
        int nwin, ndone;
        logic [25*BIT-1:0] fw;
        stream(W*H, 20, 2, nwin, ndone, fw);
        total++;
        if (nwin != 16) begin bad++; $display("FAIL ones_window_count: got %0d want 16", nwin); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        test_reset();
        test_continuous();
        test_bubbles();
        test_back_to_back();
        test_reset_mid_frame();
        test_adder_tree();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
